// File: rtl/dcore_bus_pkg.sv
// dcore_bus_pkg: shared constants and types for the core/D-cache request bus
package dcore_bus_pkg;
  localparam int BUS_DATA_WIDTH = 512;
  localparam int BUS_WORDSIZE = 64;
  localparam int BUS_TAG_WIDTH = 13;
  localparam int LINE_BYTES = BUS_DATA_WIDTH / 8;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int WORDS_PER_LINE = BUS_DATA_WIDTH / BUS_WORDSIZE;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef struct packed {
    logic [BUS_DATA_WIDTH-1:0] line;
    logic [BUS_TAG_WIDTH-1:0] tag;
  } resp_entry_t;
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: sync FIFO whose registered head holds its last value when empty
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd, wr_nx, rd_nx;
  logic push_ok, pop_ok;
  assign push_ok = push & (count != CW'(DEPTH));
  assign pop_ok = pop & (count != '0);
  // pointer successors wrap at DEPTH, which need not fill the pointer width
  always_comb begin
    wr_nx = wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
    rd_nx = rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
  end
  // storage, pointers, occupancy and the head register that always shows the oldest entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      head <= '0;
    end else begin
      if (push_ok) begin
        mem[wr] <= din;
        wr <= wr_nx;
      end
      if (pop_ok) rd <= rd_nx;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (push_ok && (count == '0 || (pop_ok && count == CW'(1)))) head <= din;
      else if (pop_ok && count > CW'(1)) head <= mem[rd_nx];
    end
  end
endmodule

// File: rtl/dcache_scratch_responder.sv
// dcache_scratch_responder: line scratchpad answering core D-cache requests in order
module dcache_scratch_responder
  import dcore_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int WORDSIZE = 64,
  parameter int TAG_WIDTH = 13,
  parameter int DEPTH_LINES = 256,
  parameter int RESP_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WORDSIZE-1:0]            req,
  input  logic [DATA_WIDTH-1:0]          reqdata,
  input  logic [DATA_WIDTH/WORDSIZE-1:0] reqwrite,
  input  logic [TAG_WIDTH-1:0]           reqtag,
  input  logic                           reqcyc,
  output logic                           reqack,
  output logic [DATA_WIDTH-1:0]          resp,
  output logic [TAG_WIDTH-1:0]           resptag,
  output logic                           respcyc,
  input  logic                           respack
);
  localparam int WORDS = DATA_WIDTH / WORDSIZE;
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(DEPTH_LINES);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH_LINES];
  logic [DATA_WIDTH-1:0] cur, line_new;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] head;
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic access;
  logic unused_addr;
  assign idx = req[OFF +: IW];
  assign unused_addr = ^{req[WORDSIZE-1:OFF+IW], req[OFF-1:0]};
  assign cur = mem[idx];
  assign access = |reqwrite ? WRITE : READ;
  assign reqack = reqcyc & ~reset & (count < CW'(RESP_DEPTH));
  assign respcyc = count != '0;
  assign {resp, resptag} = head;
  // merge written words over the stored line; this is both the new line and the response
  always_comb begin
    line_new = cur;
    for (int w = 0; w < WORDS; w++)
      line_new[w*WORDSIZE +: WORDSIZE] = reqwrite[w] ? reqdata[w*WORDSIZE +: WORDSIZE] : cur[w*WORDSIZE +: WORDSIZE];
  end
  // scratchpad update on accepted writes; contents survive reset
  always_ff @(posedge clk) begin
    if (reqack && access == WRITE) mem[idx] <= line_new;
  end
  resp_fifo #(.WIDTH(DATA_WIDTH + TAG_WIDTH), .DEPTH(RESP_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(reqack),
    .pop(respack),
    .din({line_new, reqtag}),
    .head(head),
    .count(count)
  );
endmodule
